// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame sequencer.
// Frame layout: {SYNC, value[13:8]} then value[7:0].
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        GAP
    } state_t;

    localparam logic [1:0] SYNC = 2'b10;

    function automatic logic [15:0] pack_frame(input logic [13:0] value);
        return {SYNC, value};
    endfunction

endpackage

// File: rtl/spi_frame_sequencer.sv
// Sequences the byte-level SPI master through one 2-byte frame per
// counter update, owning slave select, setup, gap and coalescing.
module spi_frame_sequencer
    import spi_frame_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int SS_SETUP   = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] count_value,
    input  logic              count_valid,
    input  logic              tx_ready,
    input  logic              done,
    output logic              start,
    output logic [7:0]        tx_data,
    output logic              ss,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);

    localparam int CNT_MAX = (SS_SETUP > GAP_CYCLES) ? SS_SETUP : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               pend;
    logic [DATA_W-1:0]  shadow;
    logic [15:0]        frame;
    logic               take;

    always_comb begin
        next_state = state;
        take       = 1'b0;
        start      = 1'b0;
        tx_data    = 8'h00;
        ss         = 1'b1;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend) begin
                    take       = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                ss = 1'b0;
                if (cnt == SETUP_LAST) next_state = SEND_HI;
            end
            SEND_HI: begin
                ss      = 1'b0;
                tx_data = frame[15:8];
                if (tx_ready) begin
                    start      = 1'b1;
                    next_state = WAIT_HI;
                end
            end
            WAIT_HI: begin
                ss      = 1'b0;
                tx_data = frame[15:8];
                if (done) next_state = SEND_LO;
            end
            SEND_LO: begin
                ss      = 1'b0;
                tx_data = frame[7:0];
                if (tx_ready) begin
                    start      = 1'b1;
                    next_state = WAIT_LO;
                end
            end
            WAIT_LO: begin
                ss      = 1'b0;
                tx_data = frame[7:0];
                if (done) begin
                    frame_done = 1'b1;
                    next_state = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= 1'b0;
            shadow   <= '0;
            frame    <= '0;
            drop_cnt <= 8'h00;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
            if (take) frame <= pack_frame(14'(shadow));
            // A pending value taken into a frame this cycle is not lost.
            if (count_valid) begin
                shadow <= count_value;
                pend   <= 1'b1;
                if (pend && !take && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'h01;
            end else if (take) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed and randomized bench for spi_frame_sequencer with a
// behavioural SPI master and a frame/coalescing reference model.
module tb_spi_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] count_value = '0;
    logic        count_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic        done = 1'b0;
    logic        start;
    logic [7:0]  tx_data;
    logic        ss;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    spi_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .count_value (count_value),
        .count_valid (count_valid),
        .tx_ready    (tx_ready),
        .done        (done),
        .start       (start),
        .tx_data     (tx_data),
        .ss          (ss),
        .busy        (busy),
        .frame_done  (frame_done),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_fd = 0;
    int start_bad = 0;
    int hold_bad = 0;
    int done_delay = 10;
    logic hold_off = 1'b0;
    logic mbusy = 1'b0;
    int mcnt = 0;
    logic st_s;
    logic [7:0] last_tx = '0;
    logic [7:0] bytes[$];
    logic [13:0] sq[$];

    // Behavioural SPI master: accepts start, answers done after done_delay.
    always @(posedge clk) begin
        st_s = start;
        if (frame_done === 1'b1) n_fd++;
        if (mbusy && busy && tx_data !== last_tx) hold_bad++;
        if (st_s === 1'b1) begin
            n_start++;
            if (tx_ready !== 1'b1) start_bad++;
            bytes.push_back(tx_data);
            last_tx = tx_data;
        end
        #1;
        done = 1'b0;
        if (st_s === 1'b1) begin
            mbusy = 1'b1;
            mcnt  = done_delay;
        end else if (mbusy) begin
            mcnt--;
            if (mcnt <= 0) begin
                done  = 1'b1;
                mbusy = 1'b0;
            end
        end
        tx_ready = !mbusy && !hold_off;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [13:0] v);
        count_value = v;
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_fd_timeout"}, 32'(n < 200), 32'd1);
    endtask

    function automatic logic [7:0] get_byte(input int i);
        return (bytes.size() > i) ? bytes[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] ref_hi(input logic [13:0] v);
        return 8'h80 + 8'(v >> 8);
    endfunction

    function automatic logic [7:0] ref_lo(input logic [13:0] v);
        return 8'(v % 256);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int fd0;
        int n;
        int idx;
        int frames;
        logic [13:0] v;
        logic [7:0] b0;

        // Reset state
        do_reset();
        check("rst_start", 32'(start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // Single update, latency and slave select timing
        bytes.delete();
        s0 = n_start;
        done_delay = 10;
        strobe(14'h1234);
        check("t1_idle_ss", 32'(ss), 32'd1);
        tick();
        check("t1_setup_ss0", 32'(ss), 32'd0);
        check("t1_setup_start0", 32'(start), 32'd0);
        tick();
        check("t1_setup_ss1", 32'(ss), 32'd0);
        check("t1_setup_start1", 32'(start), 32'd0);
        tick();
        check("t1_latency_start", 32'(start), 32'd1);
        check("t1_first_byte", 32'(tx_data), 32'(ref_hi(14'h1234)));
        check("t1_start_ss", 32'(ss), 32'd0);
        wait_fd("t1");
        check("t1_fd_ss_low", 32'(ss), 32'd0);
        tick();
        check("t1_ss_after", 32'(ss), 32'd1);
        check("t1_frame_done_pulse", 32'(frame_done), 32'd0);
        check("t1_starts", 32'(n_start - s0), 32'd2);
        check("t1_b0", 32'(get_byte(0)), 32'h92);
        check("t1_b1", 32'(get_byte(1)), 32'h34);
        repeat (10) tick();

        // Coalescing
        do_reset();
        bytes.delete();
        done_delay = 6;
        strobe(14'h0001);
        repeat (3) tick();
        strobe(14'h0002);
        tick();
        strobe(14'h0003);
        wait_fd("co1");
        tick();
        wait_fd("co2");
        repeat (30) tick();
        check("co_nbytes", 32'(bytes.size()), 32'd4);
        check("co_b0", 32'(get_byte(0)), 32'h80);
        check("co_b1", 32'(get_byte(1)), 32'h01);
        check("co_b2", 32'(get_byte(2)), 32'h80);
        check("co_b3", 32'(get_byte(3)), 32'h03);
        check("co_drop", 32'(drop_cnt), 32'd1);

        // Backpressure in SEND_HI
        do_reset();
        bytes.delete();
        hold_off = 1'b1;
        tick();
        strobe(14'h2abc);
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin
            check("bp_start_low", 32'(start), 32'd0);
            check("bp_ss_low", 32'(ss), 32'd0);
            tick();
        end
        hold_off = 1'b0;
        tick();
        check("bp_start_pulse", 32'(start), 32'd1);
        check("bp_byte", 32'(tx_data), 32'hAA);
        tick();
        check("bp_start_single", 32'(start), 32'd0);
        check("bp_ss_hold", 32'(ss), 32'd0);
        wait_fd("bp");
        repeat (10) tick();
        check("bp_b1", 32'(get_byte(1)), 32'hBC);

        // Inter-frame gap
        do_reset();
        done_delay = 3;
        strobe(14'h0100);
        tick();
        tick();
        strobe(14'h0200);
        wait_fd("gap1");
        tick();
        n = 0;
        while (ss === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check("gap_ss_high_cycles", 32'(n), 32'd5);
        wait_fd("gap2");
        repeat (10) tick();

        // Reset in WAIT_LO
        do_reset();
        bytes.delete();
        done_delay = 10;
        strobe(14'h3fff);
        tick();
        tick();
        strobe(14'h0001);
        strobe(14'h0002);
        n = 0;
        while (!(start === 1'b1 && tx_data === 8'hFF) && n < 200) begin
            tick();
            n++;
        end
        check("rm_found_lo", 32'(n < 200), 32'd1);
        tick();
        check("rm_drop_before", 32'(drop_cnt), 32'd1);
        fd0 = n_fd;
        s0 = n_start;
        reset = 1'b1;
        tick();
        check("rm_ss", 32'(ss), 32'd1);
        check("rm_start", 32'(start), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_drop", 32'(drop_cnt), 32'd0);
        check("rm_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;
        repeat (40) tick();
        check("rm_no_start", 32'(n_start - s0), 32'd0);
        check("rm_no_fd", 32'(n_fd - fd0), 32'd0);
        check("rm_idle", 32'(busy), 32'd0);

        // Saturation
        do_reset();
        done_delay = 2;
        for (int i = 0; i < 300; i++) strobe(14'(i));
        repeat (60) tick();
        check("sat_drop", 32'(drop_cnt), 32'hFF);

        // Randomized traffic against the coalescing model
        do_reset();
        bytes.delete();
        sq.delete();
        fd0 = n_fd;
        for (int i = 0; i < 500; i++) begin
            done_delay = $urandom_range(1, 12);
            hold_off = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 11) == 0) begin
                v = 14'($urandom);
                sq.push_back(v);
                strobe(v);
            end else begin
                tick();
            end
        end
        hold_off = 1'b0;
        repeat (150) tick();
        frames = bytes.size() / 2;
        check("rnd_even_bytes", 32'(bytes.size() % 2), 32'd0);
        check("rnd_fd_count", 32'(n_fd - fd0), 32'(frames));
        check("rnd_drop", 32'(drop_cnt), 32'(sq.size() - frames));
        idx = 0;
        for (int f = 0; f < frames; f++) begin
            b0 = bytes[2*f];
            v = {b0[5:0], bytes[2*f+1]};
            check("rnd_sync", 32'(b0[7:6]), 32'd2);
            while (idx < sq.size() && sq[idx] !== v) idx++;
            check("rnd_in_order", 32'(idx < sq.size()), 32'd1);
            if (idx < sq.size())
                check("rnd_hi_byte", 32'(b0), 32'(ref_hi(sq[idx])));
            idx++;
        end
        if (frames > 0 && sq.size() > 0)
            check("rnd_last", 32'({bytes[2*frames-2], bytes[2*frames-1]}),
                  32'({ref_hi(sq[sq.size()-1]), ref_lo(sq[sq.size()-1])}));

        // Handshake invariants over the whole run
        check("hs_start_ready", 32'(start_bad), 32'd0);
        check("hs_tx_stable", 32'(hold_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
